quad_adc_stream_packer: RTL and testbench
=========================================

# quad_adc_stream_packer

Downstream consumer of the four per-channel ADC deserializers. It brings the frame-rate 14-bit samples of channels A–D into the fabric clock domain and packs each simultaneous sample set into one 64-bit AXI4-Stream word. It buffers words in a small FIFO and emits fixed-length packets (TLAST) for the DMA engine, counting any samples it has to drop.

## Interface
Parameters:
- PACKET_LEN, 256: sample sets per packet; TLAST on the last word; 2..65535.
- FIFO_DEPTH, 16: FIFO words; power of two, ≥4.

Ports:
- ACLK  in  1  fabric clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  capture enable (ACLK domain).
- FRAME_CLK  in  1  deserializer frame clock, treated as asynchronous data; high and low phases each ≥3 ACLK periods.
- CH_A_DATA … CH_D_DATA  in  14 each  deserialized samples; stable ≥2 ACLK cycles after FRAME_CLK rises until the next rise.
- M_AXIS_TDATA  out  64  {2'b0,D,2'b0,C,2'b0,B,2'b0,A}, raw zero-extended.
- M_AXIS_TVALID  out  1  FIFO non-empty.
- M_AXIS_TREADY  in  1  consumer ready.
- M_AXIS_TLAST  out  1  head word closes a packet.
- OVERFLOW_COUNT  out  32  dropped sample sets, saturating at 32'hFFFF_FFFF.
- BUSY  out  1  state ≠ IDLE.

## Operation
- FRAME_CLK passes through a 3-flop chain (sync1, sync2, sync3); the strobe is sync2 & ~sync3. Chain flops reset to 1, so a FRAME_CLK that is high at reset release does not produce a strobe.
- On a strobe in RUN or FINISH: capture all four CH_*_DATA, then either push {tlast, word} or drop.
  - tlast = (pkt_cnt == PACKET_LEN-1).
  - pkt_cnt counts pushed words only and wraps to 0 after a tlast push. Drops never shorten or lengthen a packet.
- Full rule: a push is dropped if the FIFO is full at the start of the cycle, even if a pop occurs in the same cycle. A drop increments OVERFLOW_COUNT (saturating) and does not advance pkt_cnt.
- Pop when M_AXIS_TVALID & M_AXIS_TREADY. TDATA and TLAST show the FIFO head and are stable while TVALID is high and TREADY is low.
- State machine:
  - IDLE → RUN when ENABLE=1 (pkt_cnt=0). No captures in IDLE.
  - RUN → IDLE when ENABLE=0 and pkt_cnt=0.
  - RUN → FINISH when ENABLE=0 and pkt_cnt≠0.
  - FINISH: keeps capturing until the tlast word is pushed, then → IDLE. ENABLE re-asserted in FINISH has no effect until IDLE is reached.
- Enable and a strobe in the same cycle while in IDLE: the strobe is ignored; capture starts on the next strobe.
- The FIFO drains normally in every state. Words already in the FIFO are never discarded except by reset.

## Timing
- Reset values: TVALID=0, TLAST=0, TDATA=0, OVERFLOW_COUNT=0, BUSY=0, state=IDLE, FIFO empty, pkt_cnt=0.
- Reset mid-packet clears everything immediately; the partial packet is lost.
- Latency: FRAME_CLK first sampled high at ACLK edge n → FIFO write at edge n+2 → TVALID high after edge n+2 if the FIFO was empty.
- Throughput: one word per cycle out. Input rate ≤ one set per 6 ACLK cycles.
- BUSY and state change on the edge after the triggering condition.

## Structure
- Shared package (quad_adc_pkg):
  - SAMPLE_W=14, NUM_CH=4, LANE_W=16, TDATA_W=64.
  - State encoding: IDLE=2'd0, RUN=2'd1, FINISH=2'd2.
- Sub-module adc_sample_fifo:
  - Synchronous FIFO, 65-bit word (tlast + data), depth FIFO_DEPTH, same ACLK/ARESETN.
  - Pointer-based with a count; full/empty registered from count.
- Top level holds the synchronizer, FSM, packet counter and overflow counter.

## Test plan
- Reset release with FRAME_CLK high, ENABLE=1, TREADY=1 → no word until the next FRAME_CLK rise; first word TVALID after edge n+2 with TDATA = {0,D,0,C,0,B,0,A} of driven values (A=14'h1ABC → TDATA[13:0]=14'h1ABC).
- PACKET_LEN=4, TREADY=1, 12 frames → 12 words; TLAST on words 4, 8, 12; OVERFLOW_COUNT=0.
- FIFO_DEPTH=4, TREADY=0, 7 frames → 4 words buffered, OVERFLOW_COUNT=3. Then TREADY=1 → 4 words in order, and the next pushed word continues pkt_cnt at 4.
- PACKET_LEN=8, ENABLE dropped after 3 pushes → BUSY stays high through 5 more frames, TLAST on the 8th word, then IDLE with BUSY=0 and no further words.
- ARESETN pulsed low mid-packet with 3 words queued → TVALID=0 and OVERFLOW_COUNT=0 immediately. After re-enable, the first packet starts at pkt_cnt=0.

Source files
------------

// File: rtl/quad_adc_pkg.sv
// Shared types and constants for the quad ADC stream packer.
package quad_adc_pkg;

  localparam int SAMPLE_W = 14;
  localparam int NUM_CH   = 4;
  localparam int LANE_W   = 16;
  localparam int TDATA_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } pkt_state_e;

  typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] sample_set_t;

  // Places each channel's sample zero-extended in its own 16-bit lane, channel A lowest.
  function automatic logic [TDATA_W-1:0] pack_samples(input sample_set_t samples);
    logic [TDATA_W-1:0] word;
    word = {TDATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      word[i*LANE_W +: LANE_W] = {{(LANE_W-SAMPLE_W){1'b0}}, samples[i]};
    end
    return word;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous word FIFO with registered full/empty flags derived from an occupancy count.
// A write presented while full is ignored, even if a read happens in the same cycle.
module adc_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign wr_ok_s = wr_en & ~full_r;
  assign rd_ok_s = rd_en & ~empty_r;

  // Occupancy after this cycle's accepted write and read.
  always_comb begin
    count_nxt_s = count_r;
    if (wr_ok_s && !rd_ok_s) begin
      count_nxt_s = count_r + 1'b1;
    end else if (!wr_ok_s && rd_ok_s) begin
      count_nxt_s = count_r - 1'b1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; cleared on reset so the head reads zero when nothing was written.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, count and status flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == {(AW+1){1'b0}});
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/quad_adc_stream_packer.sv
// Packs simultaneous 14-bit samples of four ADC channels into 64-bit AXI4-Stream
// words, grouped into fixed-length packets, and counts sample sets lost to a full FIFO.
module quad_adc_stream_packer
  import quad_adc_pkg::*;
#(
  parameter int PACKET_LEN = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                ENABLE,
  input  logic                FRAME_CLK,
  input  logic [SAMPLE_W-1:0] CH_A_DATA,
  input  logic [SAMPLE_W-1:0] CH_B_DATA,
  input  logic [SAMPLE_W-1:0] CH_C_DATA,
  input  logic [SAMPLE_W-1:0] CH_D_DATA,
  output logic [TDATA_W-1:0]  M_AXIS_TDATA,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic                M_AXIS_TLAST,
  output logic [31:0]         OVERFLOW_COUNT,
  output logic                BUSY
);

  localparam logic [15:0] LAST_CNT = 16'(PACKET_LEN - 1);

  logic        sync1_r, sync2_r, sync3_r;
  logic        strobe_s;
  pkt_state_e  state_r, state_nxt_s;
  logic [15:0] pkt_cnt_r, pkt_cnt_nxt_s;
  logic [31:0] ovf_cnt_r;
  logic        busy_r;
  logic        capture_s, push_s, drop_s, tlast_s;
  logic        fifo_full_s, fifo_empty_s, pop_s;
  logic [TDATA_W:0] fifo_head_s;
  sample_set_t samples_s;

  // Frame clock synchronizer; flops preset so a level already high at reset release is not an edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      sync3_r <= 1'b1;
    end else begin
      sync1_r <= FRAME_CLK;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign strobe_s  = sync2_r & ~sync3_r;
  assign capture_s = strobe_s & (state_r != ST_IDLE);
  assign push_s    = capture_s & ~fifo_full_s;
  assign drop_s    = capture_s & fifo_full_s;
  assign tlast_s   = (pkt_cnt_r == LAST_CNT);
  assign samples_s = {CH_D_DATA, CH_C_DATA, CH_B_DATA, CH_A_DATA};
  assign pop_s     = ~fifo_empty_s & M_AXIS_TREADY;

  // Packet position advances only on accepted words and wraps after the closing word.
  always_comb begin
    pkt_cnt_nxt_s = pkt_cnt_r;
    if (push_s) begin
      if (tlast_s) begin
        pkt_cnt_nxt_s = 16'd0;
      end else begin
        pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
      end
    end else begin
      pkt_cnt_nxt_s = pkt_cnt_r;
    end
  end

  // Capture state machine: leaving RUN mid-packet finishes the packet before going idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ENABLE) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ENABLE) begin
          state_nxt_s = ST_RUN;
        end else if (pkt_cnt_nxt_s == 16'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (push_s && tlast_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FINISH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, packet position, busy flag and saturating drop counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r   <= ST_IDLE;
      pkt_cnt_r <= 16'd0;
      busy_r    <= 1'b0;
      ovf_cnt_r <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      pkt_cnt_r <= pkt_cnt_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      if (drop_s && (ovf_cnt_r != 32'hFFFF_FFFF)) begin
        ovf_cnt_r <= ovf_cnt_r + 32'd1;
      end
    end
  end

  adc_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TDATA_W + 1)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (push_s),
    .wr_data ({tlast_s, pack_samples(samples_s)}),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign M_AXIS_TDATA   = fifo_head_s[TDATA_W-1:0];
  assign M_AXIS_TLAST   = fifo_head_s[TDATA_W];
  assign M_AXIS_TVALID  = ~fifo_empty_s;
  assign OVERFLOW_COUNT = ovf_cnt_r;
  assign BUSY           = busy_r;

endmodule

// File: tb/tb_quad_adc_stream_packer.sv
// Scoreboard bench for quad_adc_stream_packer: stimulus pushes expected words,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_quad_adc_stream_packer;

  localparam int PLEN   = 4;
  localparam int FDEPTH = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        ENABLE = 1'b0;
  logic        FRAME_CLK = 1'b0;
  logic [13:0] ch_a = 14'd0, ch_b = 14'd0, ch_c = 14'd0, ch_d = 14'd0;
  logic [63:0] tdata;
  logic        tvalid, tlast, busy;
  logic        tready = 1'b0;
  logic [31:0] ovf;

  logic [64:0] exp_q [$];
  int checks = 0;
  int passes = 0;

  quad_adc_stream_packer #(.PACKET_LEN(PLEN), .FIFO_DEPTH(FDEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .FRAME_CLK(FRAME_CLK),
    .CH_A_DATA(ch_a), .CH_B_DATA(ch_b), .CH_C_DATA(ch_c), .CH_D_DATA(ch_d),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast), .OVERFLOW_COUNT(ovf), .BUSY(busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected {tlast, data} entry.
  always @(negedge ACLK) begin
    if (ARESETN && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %b/%h, expected no word", tlast, tdata);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("word_tdata", tdata, e[63:0]);
        check("word_tlast", {63'd0, tlast}, {63'd0, e[64]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  function automatic logic [64:0] mk(input logic l, input logic [13:0] a, b, c, d);
    return {l, 2'b00, d, 2'b00, c, 2'b00, b, 2'b00, a};
  endfunction

  // One FRAME_CLK period of 8 ACLK cycles carrying sample set i.
  task automatic send_idx(input int i, input bit exp_push, input bit exp_last);
    ch_a = 14'(16'h0A00 + i);
    ch_b = 14'(16'h1B00 + i);
    ch_c = 14'(16'h2C00 + i);
    ch_d = 14'(16'h3D00 + i);
    if (exp_push) exp_q.push_back(mk(exp_last, ch_a, ch_b, ch_c, ch_d));
    FRAME_CLK = 1'b1;
    tick(4);
    FRAME_CLK = 1'b0;
    tick(4);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    tready = 1'b0;
    ENABLE = 1'b0;
    FRAME_CLK = 1'b0;
    ARESETN = 1'b0;
    tick(2);
    ARESETN = 1'b1;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values, released with FRAME_CLK high.
    FRAME_CLK = 1'b1;
    ENABLE = 1'b1;
    tready = 1'b1;
    ARESETN = 1'b0;
    tick(2);
    check("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("rst_tlast", {63'd0, tlast}, 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_ovf", {32'd0, ovf}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    ARESETN = 1'b1;
    tick(6);
    check("no_word_high_at_release", {63'd0, tvalid}, 64'd0);
    check("busy_after_enable", {63'd0, busy}, 64'd1);
    FRAME_CLK = 1'b0;
    tick(4);
    ch_a = 14'h1ABC; ch_b = 14'h0123; ch_c = 14'h3FFF; ch_d = 14'h2001;
    exp_q.push_back({1'b0, 64'h2001_3FFF_0123_1ABC});
    FRAME_CLK = 1'b1;
    tick(2);
    check("latency_not_before_n2", {63'd0, tvalid}, 64'd0);
    tick(1);
    check("latency_valid_at_n2", {63'd0, tvalid}, 64'd1);
    check("first_lane_a", {50'd0, tdata[13:0]}, 64'h1ABC);
    tick(2);
    FRAME_CLK = 1'b0;
    tick(4);
    wait_drain();

    // Twelve frames streaming: TLAST on words 4, 8, 12.
    do_reset();
    ENABLE = 1'b1;
    tready = 1'b1;
    tick(1);
    for (int i = 0; i < 12; i++) send_idx(i, 1'b1, (i % PLEN) == PLEN - 1);
    wait_drain();
    check("stream_ovf_zero", {32'd0, ovf}, 64'd0);

    // Overflow: 7 frames with consumer stalled, then drain and continue.
    do_reset();
    ENABLE = 1'b1;
    tready = 1'b0;
    tick(1);
    for (int i = 0; i < 7; i++) send_idx(100 + i, i < 4, i == 3);
    check("ovf_tvalid", {63'd0, tvalid}, 64'd1);
    check("ovf_count3", {32'd0, ovf}, 64'd3);
    check("ovf_head_held", tdata, exp_q[0][63:0]);
    tready = 1'b1;
    wait_drain();
    for (int i = 0; i < 4; i++) send_idx(110 + i, 1'b1, i == 3);
    wait_drain();
    check("ovf_count_kept", {32'd0, ovf}, 64'd3);

    // ENABLE dropped mid-packet: finish the packet, then idle.
    do_reset();
    ENABLE = 1'b1;
    tready = 1'b1;
    tick(1);
    send_idx(200, 1'b1, 1'b0);
    send_idx(201, 1'b1, 1'b0);
    ENABLE = 1'b0;
    tick(2);
    check("finish_busy_a", {63'd0, busy}, 64'd1);
    send_idx(202, 1'b1, 1'b0);
    check("finish_busy_b", {63'd0, busy}, 64'd1);
    send_idx(203, 1'b1, 1'b1);
    check("finish_idle_busy", {63'd0, busy}, 64'd0);
    send_idx(204, 1'b0, 1'b0);
    send_idx(205, 1'b0, 1'b0);
    wait_drain();
    check("idle_no_words", {63'd0, tvalid}, 64'd0);

    // Reset mid-packet with three words queued.
    do_reset();
    ENABLE = 1'b1;
    tready = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) send_idx(300 + i, 1'b0, 1'b0);
    check("pre_reset_tvalid", {63'd0, tvalid}, 64'd1);
    #3;
    ARESETN = 1'b0;
    #1;
    check("midrst_tvalid", {63'd0, tvalid}, 64'd0);
    check("midrst_ovf", {32'd0, ovf}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    tick(1);
    ARESETN = 1'b1;
    ENABLE = 1'b1;
    tready = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) send_idx(400 + i, 1'b1, i == 3);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
